// File: rtl/dmem_store_buffer_pkg.sv
// rtl/dmem_store_buffer_pkg.sv - shared entry type, constants and byte merge for the store buffer
package dmem_store_buffer_pkg;

   localparam int BE_W     = 4;
   localparam int WORD_OFS = 2;
   localparam int SB_AW    = 32;

   typedef struct packed {
      logic [SB_AW-1:WORD_OFS] addr;
      logic [31:0]             data;
      logic [BE_W-1:0]         be;
   } sb_entry_t;

   typedef enum logic {
      SB_IDLE,
      SB_ACTIVE
   } sb_state_t;

   function automatic logic [31:0] byte_merge(input logic [31:0]     i_new,
                                              input logic [31:0]     i_old,
                                              input logic [BE_W-1:0] i_be);
      logic [31:0] v_word;
      v_word = i_old;
      for (int b = 0; b < BE_W; b++) begin
         if (i_be[b]) v_word[8*b +: 8] = i_new[8*b +: 8];
      end
      return v_word;
   endfunction

endpackage

// File: rtl/dmem_store_buffer_fwd_merge.sv
// rtl/dmem_store_buffer_fwd_merge.sv - sb_fwd_merge: overlays buffered store bytes on a load word
// Entries are walked oldest to youngest so the youngest byte in each lane wins.
module sb_fwd_merge
   import dmem_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t               i_entries [DEPTH],
   input  logic [PTR_W-1:0]        i_head,
   input  logic [PTR_W:0]          i_count,
   input  logic [SB_AW-1:WORD_OFS] i_ld_word,
   input  logic [31:0]             i_mem_rd,
   output logic [31:0]             o_rdata
);

   always_comb begin
      logic [PTR_W-1:0] v_idx;
      v_idx   = i_head;
      o_rdata = i_mem_rd;
      for (int k = 0; k < DEPTH; k++) begin
         v_idx = i_head + PTR_W'(k);
         if ((k < int'(i_count)) && (i_entries[v_idx].addr == i_ld_word)) begin
            o_rdata = byte_merge(i_entries[v_idx].data, o_rdata, i_entries[v_idx].be);
         end
      end
   end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - FIFO store buffer in front of dmem with load forwarding
// Optional same-word coalescing into the youngest entry: STORE_BUF_COALESCE_EN.
module dmem_store_buffer
   import dmem_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [31:0]   st_wdata,
   input  logic [3:0]    st_be,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   output logic [31:0]   ld_rdata,
   input  logic          fence,
   output logic          empty,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [31:0]   mem_wd,
   input  logic [31:0]   mem_rd
);

   localparam int EAW = SB_AW - WORD_OFS;

   sb_entry_t        r_entries [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   sb_state_t        r_state;

   logic [EAW-1:0]   w_st_word;
   logic [EAW-1:0]   w_ld_word;
   logic             w_full;
   logic             w_active;
   logic             w_pop;
   logic             w_merge;
   logic             w_accept;
   logic             w_push;
   logic             w_merge_wr;
   logic             w_unused;

   assign w_st_word = EAW'(st_addr[AW-1:WORD_OFS]);
   assign w_ld_word = EAW'(ld_addr[AW-1:WORD_OFS]);
   assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign w_active  = (r_state == SB_ACTIVE);
   assign w_pop     = !ld_req && w_active;
   assign w_unused  = &{1'b0, st_addr[WORD_OFS-1:0], ld_addr[WORD_OFS-1:0], fence};

`ifdef STORE_BUF_COALESCE_EN
   logic [PTR_W-1:0] w_youngest;
   assign w_youngest = r_tail - PTR_W'(1);
   // A lone entry that is draining this cycle must not absorb new bytes.
   assign w_merge = w_active && (r_entries[w_youngest].addr == w_st_word) &&
                    !(w_pop && (r_count == (PTR_W+1)'(1)));
`else
   assign w_merge = 1'b0;
`endif

   assign st_ready   = !w_full || w_merge;
   assign w_accept   = st_valid && st_ready && (st_be != '0);
   assign w_push     = w_accept && !w_merge;
   assign w_merge_wr = w_accept && w_merge;
   assign empty      = (r_state == SB_IDLE);

   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (ld_req) begin
         mem_a = {ld_addr[AW-1:WORD_OFS], 2'b00};
      end else if (w_active) begin
         mem_we = 1'b1;
         mem_a  = AW'({r_entries[r_head].addr, 2'b00});
         mem_wd = byte_merge(r_entries[r_head].data, mem_rd, r_entries[r_head].be);
      end
   end

   sb_fwd_merge #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fwd (
      .i_entries (r_entries),
      .i_head    (r_head),
      .i_count   (r_count),
      .i_ld_word (w_ld_word),
      .i_mem_rd  (mem_rd),
      .o_rdata   (ld_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_state <= SB_IDLE;
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      end else begin
         if (w_push) begin
            r_entries[r_tail] <= '{addr: w_st_word, data: st_wdata, be: st_be};
            r_tail            <= r_tail + PTR_W'(1);
         end
`ifdef STORE_BUF_COALESCE_EN
         if (w_merge_wr) begin
            r_entries[w_youngest].data <= byte_merge(st_wdata, r_entries[w_youngest].data, st_be);
            r_entries[w_youngest].be   <= r_entries[w_youngest].be | st_be;
         end
`endif
         if (w_pop) r_head <= r_head + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
         case (r_state)
            SB_IDLE:   if (w_push) r_state <= SB_ACTIVE;
            SB_ACTIVE: if (w_pop && !w_push && (r_count == (PTR_W+1)'(1))) r_state <= SB_IDLE;
            default:   r_state <= SB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - scoreboard bench for dmem_store_buffer with a behavioural dmem
module tb_dmem_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic [3:0]  st_be;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [31:0] ld_rdata;
   logic        fence;
   logic        empty;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] dmem [64];
   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_data;

   logic [63:0] exp_q [$];
   int          n_pass  = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .st_valid (st_valid),
      .st_ready (st_ready),
      .st_addr  (st_addr),
      .st_wdata (st_wdata),
      .st_be    (st_be),
      .ld_req   (ld_req),
      .ld_addr  (ld_addr),
      .ld_rdata (ld_rdata),
      .fence    (fence),
      .empty    (empty),
      .mem_we   (mem_we),
      .mem_a    (mem_a),
      .mem_wd   (mem_wd),
      .mem_rd   (mem_rd)
   );

   assign mem_rd = dmem[mem_a[7:2]];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
      end else if (pre_we) begin
         dmem[pre_idx] <= pre_data;
      end else if (mem_we) begin
         dmem[mem_a[7:2]] <= mem_wd;
      end
   end

   // One clock: scoreboard-check any dmem write at the falling edge, then move to just after the rising edge.
   task automatic step();
      logic [63:0] e;
      @(negedge clk);
      if (mem_we && !reset) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_write actual a=%h wd=%h required no write", mem_a, mem_wd);
         end else begin
            e = exp_q.pop_front();
            if ({mem_a, mem_wd} !== e)
               $display("FAIL sb_write actual a=%h wd=%h required a=%h wd=%h", mem_a, mem_wd, e[63:32], e[31:0]);
            else
               n_pass++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      st_valid = 1'b1;
      st_addr  = a;
      st_wdata = d;
      st_be    = be;
      step();
      st_valid = 1'b0;
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = d;
      step();
      pre_we   = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int i;
      i = 0;
      while (!empty && i < 60) begin
         step();
         i++;
      end
      n_total++;
      if (empty !== 1'b1) $display("FAIL %s_drain_timeout actual empty=%b required 1", name, empty);
      else n_pass++;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_total++;
      if (empty !== 1'b1) $display("FAIL reset_empty actual %b required 1", empty); else n_pass++;
      n_total++;
      if (st_ready !== 1'b1) $display("FAIL reset_st_ready actual %b required 1", st_ready); else n_pass++;
      n_total++;
      if (mem_we !== 1'b0) $display("FAIL reset_mem_we actual %b required 0", mem_we); else n_pass++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_word_store();
      exp_q.push_back({32'h10, 32'h11223344});
      push(32'h10, 32'h11223344, 4'hF);
      n_total++;
      if (mem_we !== 1'b1) $display("FAIL word_mem_we actual %b required 1", mem_we); else n_pass++;
      n_total++;
      if (mem_a !== 32'h10) $display("FAIL word_mem_a actual %h required 00000010", mem_a); else n_pass++;
      n_total++;
      if (mem_wd !== 32'h11223344) $display("FAIL word_mem_wd actual %h required 11223344", mem_wd); else n_pass++;
      step();
      n_total++;
      if (empty !== 1'b1) $display("FAIL word_empty_after actual %b required 1", empty); else n_pass++;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL word_sb_left actual %0d required 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_byte_store();
      preload(6'd8, 32'hAABBCCDD);
      exp_q.push_back({32'h20, 32'hAABB55DD});
      push(32'h21, 32'h00005500, 4'b0010);
      wait_empty("byte");
      n_total++;
      if (exp_q.size() != 0) $display("FAIL byte_sb_left actual %0d required 0", exp_q.size()); else n_pass++;
      n_total++;
      if (dmem[8] !== 32'hAABB55DD) $display("FAIL byte_dmem actual %h required aabb55dd", dmem[8]); else n_pass++;
   endtask

   task automatic test_load_fwd();
      ld_req  = 1'b1;
      ld_addr = 32'h30;
      push(32'h30, 32'hDEADBEEF, 4'hF);
      for (int c = 0; c < 2; c++) begin
         n_total++;
         if (ld_rdata !== 32'hDEADBEEF) $display("FAIL fwd_word_c%0d actual %h required deadbeef", c, ld_rdata); else n_pass++;
         n_total++;
         if (mem_we !== 1'b0) $display("FAIL fwd_no_drain_c%0d actual %b required 0", c, mem_we); else n_pass++;
         n_total++;
         if (mem_a !== 32'h30) $display("FAIL fwd_mem_a_c%0d actual %h required 00000030", c, mem_a); else n_pass++;
         step();
      end
      exp_q.push_back({32'h30, 32'hDEADBEEF});
      ld_req = 1'b0;
      wait_empty("fwd_word");

      preload(6'd13, 32'h01020304);
      ld_req  = 1'b1;
      ld_addr = 32'h34;
      #1;
      n_total++;
      if (ld_rdata !== 32'h01020304) $display("FAIL fwd_none actual %h required 01020304", ld_rdata); else n_pass++;
      push(32'h34, 32'h00000011, 4'b0001);
      push(32'h34, 32'h00002222, 4'b0011);
      n_total++;
      if (ld_rdata !== 32'h01022222) $display("FAIL fwd_youngest actual %h required 01022222", ld_rdata); else n_pass++;
`ifdef STORE_BUF_COALESCE_EN
      exp_q.push_back({32'h34, 32'h01022222});
`else
      exp_q.push_back({32'h34, 32'h01020311});
      exp_q.push_back({32'h34, 32'h01022222});
`endif
      ld_req = 1'b0;
      wait_empty("fwd_partial");
      n_total++;
      if (exp_q.size() != 0) $display("FAIL fwd_sb_left actual %0d required 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_fill();
      reset_pulse();
      ld_req  = 1'b1;
      ld_addr = 32'h80;
      for (int i = 0; i < 4; i++) begin
         push(32'(4 * i), 32'hA0000000 + 32'(i), 4'hF);
         exp_q.push_back({32'(4 * i), 32'hA0000000 + 32'(i)});
      end
      st_addr = 32'h50;
      #1;
      n_total++;
      if (st_ready !== 1'b0) $display("FAIL fill_full_ready actual %b required 0", st_ready); else n_pass++;
      push(32'h50, 32'h55555555, 4'hF);
      n_total++;
      if (st_ready !== 1'b0) $display("FAIL fill_stalled_ready actual %b required 0", st_ready); else n_pass++;
      ld_req = 1'b0;
      fence  = 1'b1;
      wait_empty("fill");
      fence  = 1'b0;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL fill_sb_left actual %0d required 0", exp_q.size()); else n_pass++;
      n_total++;
      if (dut.r_head !== 2'd0) $display("FAIL fill_head_wrap actual %0d required 0", dut.r_head); else n_pass++;
      n_total++;
      if (st_ready !== 1'b1) $display("FAIL fill_ready_after actual %b required 1", st_ready); else n_pass++;
   endtask

   task automatic test_reset_mid_drain();
      ld_req  = 1'b1;
      ld_addr = 32'h80;
      push(32'h60, 32'h60606060, 4'hF);
      push(32'h64, 32'h64646464, 4'hF);
      push(32'h68, 32'h68686868, 4'hF);
      exp_q.push_back({32'h60, 32'h60606060});
      ld_req = 1'b0;
      step();
      #1 reset = 1'b1;
      #1;
      n_total++;
      if (empty !== 1'b1) $display("FAIL rmid_empty actual %b required 1", empty); else n_pass++;
      n_total++;
      if (st_ready !== 1'b1) $display("FAIL rmid_ready actual %b required 1", st_ready); else n_pass++;
      n_total++;
      if (mem_we !== 1'b0) $display("FAIL rmid_mem_we actual %b required 0", mem_we); else n_pass++;
      step();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) step();
      n_total++;
      if (empty !== 1'b1) $display("FAIL rmid_empty_later actual %b required 1", empty); else n_pass++;
      n_total++;
      if (mem_we !== 1'b0) $display("FAIL rmid_mem_we_later actual %b required 0", mem_we); else n_pass++;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL rmid_sb_left actual %0d required 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_coalesce();
      reset_pulse();
      preload(6'd16, 32'h12345678);
      ld_req  = 1'b1;
      ld_addr = 32'h80;
      push(32'h40, 32'h000000AA, 4'b0001);
      push(32'h40, 32'hBB000000, 4'b1000);
`ifdef STORE_BUF_COALESCE_EN
      n_total++;
      if (dut.r_count !== 3'd1) $display("FAIL coal_count actual %0d required 1", dut.r_count); else n_pass++;
      exp_q.push_back({32'h40, 32'hBB3456AA});
`else
      n_total++;
      if (dut.r_count !== 3'd2) $display("FAIL coal_count actual %0d required 2", dut.r_count); else n_pass++;
      exp_q.push_back({32'h40, 32'h123456AA});
      exp_q.push_back({32'h40, 32'hBB3456AA});
`endif
      ld_req = 1'b0;
      wait_empty("coal");
      n_total++;
      if (exp_q.size() != 0) $display("FAIL coal_sb_left actual %0d required 0", exp_q.size()); else n_pass++;
      n_total++;
      if (dmem[16] !== 32'hBB3456AA) $display("FAIL coal_dmem actual %h required bb3456aa", dmem[16]); else n_pass++;
   endtask

   initial begin
      reset    = 1'b1;
      st_valid = 1'b0;
      st_addr  = 32'h0;
      st_wdata = 32'h0;
      st_be    = 4'h0;
      ld_req   = 1'b0;
      ld_addr  = 32'h0;
      fence    = 1'b0;
      pre_we   = 1'b0;
      pre_idx  = 6'd0;
      pre_data = 32'h0;
      test_reset();
      test_word_store();
      test_byte_store();
      test_load_fwd();
      test_fill();
      test_reset_mid_drain();
      test_coalesce();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
